// File: rtl/song_scheduler.sv
// song_scheduler
//
// Shares the single key_code input of the audio module among NUM_SONGS song
// player modules. Play requests are queued as a pending bit per song and
// granted by fixed priority (index 0 highest). The granted song is first held
// in reset for RESTART_CYCLES so it rewinds, then enabled while its key code
// is forwarded. SILENCE_LIMIT consecutive 8'hf0 codes end the song. A gap of
// silence follows before the next grant.
//
// Ports:
//   clock          system clock, all logic on posedge
//   resetter       synchronous active-high reset
//   play_req       per-song request, a 1 in any cycle queues that song
//   stop           one-cycle abort of the current song (START/PLAY only)
//   song_key_code  key codes from the song modules, song i at [8i+7:8i]
//   song_enable    per-song run line (active-low reset of the song module)
//   key_code       registered key code to the audio module
//   busy           high in START, PLAY and GAP
//   active_song    index of the granted song, holds its value in IDLE
//   done           one-cycle pulse when a song ends by silence
module song_scheduler #(
  parameter int unsigned NUM_SONGS      = 4,
  parameter int unsigned RESTART_CYCLES = 4,
  parameter int unsigned SILENCE_LIMIT  = 4096,
  parameter int unsigned GAP_CYCLES     = 1024,
  parameter bit          PREEMPT        = 1'b1,
  localparam int unsigned AW            = (NUM_SONGS > 1) ? $clog2(NUM_SONGS) : 1
) (
  input  logic                   clock,
  input  logic                   resetter,
  input  logic [NUM_SONGS-1:0]   play_req,
  input  logic                   stop,
  input  logic [8*NUM_SONGS-1:0] song_key_code,
  output logic [NUM_SONGS-1:0]   song_enable,
  output logic [7:0]             key_code,
  output logic                   busy,
  output logic [AW-1:0]          active_song,
  output logic                   done
);

  localparam logic [7:0] SilentCode = 8'hf0;

  // Terminal counts; a zero parameter behaves like one.
  localparam logic [15:0] RestartLast =
      (RESTART_CYCLES > 0) ? 16'(RESTART_CYCLES - 1) : 16'd0;
  localparam logic [15:0] SilenceLast =
      (SILENCE_LIMIT > 0) ? 16'(SILENCE_LIMIT - 1) : 16'd0;
  localparam logic [15:0] GapLast =
      (GAP_CYCLES > 0) ? 16'(GAP_CYCLES - 1) : 16'd0;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StPlay,
    StGap
  } state_e;

  state_e               state_q, state_d;
  logic [NUM_SONGS-1:0] pending_q, pending_d;
  logic [AW-1:0]        active_q, active_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [15:0]          silence_q, silence_d;
  logic [7:0]           key_q, key_d;
  logic                 done_q, done_d;

  logic [NUM_SONGS-1:0] grant_mask;
  logic [AW-1:0]        sel_idx;
  logic                 any_pending;
  logic                 preempt_hit;
  logic [7:0]           sel_code;
  logic                 silence_hit;

  // Lowest set index of pending wins.
  always_comb begin
    sel_idx = '0;
    for (int i = NUM_SONGS - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        sel_idx = AW'(i);
      end
    end
  end

  assign any_pending = |pending_q;

  // The lowest pending index is strictly higher priority than the active song
  // exactly when it is numerically smaller.
  assign preempt_hit = PREEMPT && any_pending && (sel_idx < active_q);

  // Key code of the granted song.
  always_comb begin
    sel_code = SilentCode;
    for (int i = 0; i < NUM_SONGS; i++) begin
      if (active_q == AW'(i)) begin
        sel_code = song_key_code[8*i +: 8];
      end
    end
  end

  assign silence_hit = (sel_code == SilentCode);

  // State register.
  always_ff @(posedge clock) begin
    if (resetter) begin
      state_q   <= StIdle;
      pending_q <= '0;
      active_q  <= '0;
      cnt_q     <= '0;
      silence_q <= '0;
      key_q     <= SilentCode;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      active_q  <= active_d;
      cnt_q     <= cnt_d;
      silence_q <= silence_d;
      key_q     <= key_d;
      done_q    <= done_d;
    end
  end

  // Next-state logic. Event priority: stop, preempt, silence end.
  always_comb begin
    state_d    = state_q;
    active_d   = active_q;
    cnt_d      = cnt_q;
    silence_d  = '0;
    done_d     = 1'b0;
    grant_mask = '0;

    unique case (state_q)
      StIdle: begin
        if (any_pending) begin
          grant_mask = NUM_SONGS'(1) << sel_idx;
          active_d   = sel_idx;
          state_d    = StStart;
          cnt_d      = '0;
        end
      end

      StStart: begin
        if (stop) begin
          state_d = StGap;
          cnt_d   = '0;
        end else if (preempt_hit) begin
          grant_mask = NUM_SONGS'(1) << sel_idx;
          active_d   = sel_idx;
          cnt_d      = '0;
        end else if (cnt_q == RestartLast) begin
          state_d = StPlay;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      StPlay: begin
        if (silence_hit) begin
          silence_d = (silence_q == 16'hffff) ? silence_q : silence_q + 16'd1;
        end
        if (stop) begin
          state_d = StGap;
          cnt_d   = '0;
        end else if (preempt_hit) begin
          grant_mask = NUM_SONGS'(1) << sel_idx;
          active_d   = sel_idx;
          state_d    = StStart;
          cnt_d      = '0;
        end else if (silence_hit && (silence_q == SilenceLast)) begin
          // This cycle is the SILENCE_LIMIT-th consecutive silent code.
          state_d = StGap;
          cnt_d   = '0;
          done_d  = 1'b1;
        end
      end

      StGap: begin
        if (cnt_q == GapLast) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // A request for the song granted this cycle survives the clear and replays.
  assign pending_d = (pending_q & ~grant_mask) | play_req;

  // Outputs.
  always_comb begin
    song_enable = '0;
    if (state_q == StPlay) begin
      song_enable = NUM_SONGS'(1) << active_q;
    end
    busy = (state_q != StIdle);
    // Only forward a note when PLAY continues, so no note lingers into START or GAP.
    key_d = ((state_q == StPlay) && (state_d == StPlay)) ? sel_code : SilentCode;
  end

  assign key_code    = key_q;
  assign active_song = active_q;
  assign done        = done_q;

endmodule

// File: doc/song_scheduler.md
Name: song_scheduler

Overview:
Sequences up to NUM_SONGS song player modules onto the single key_code input of the audio module. Game logic issues play requests. The scheduler queues them and picks one song by fixed priority. It drives that song's run/reset line and muxes its key_code to the output. End of song is detected by sustained silence (8'hf0), followed by an inter-song gap.

Parameters:
NUM_SONGS, 4, number of song player modules attached (index 0 = highest priority)
RESTART_CYCLES, 4, cycles all song enables are held low before a newly granted song runs (rewinds the song module)
SILENCE_LIMIT, 4096, consecutive 8'hf0 cycles on the active song that mark end of song; must exceed the longest rest in any song
GAP_CYCLES, 1024, silent cycles between songs; 0 is treated as 1
PREEMPT, 1, 1 = pending request of strictly higher priority aborts the current song

Ports:
clock  input  1  system clock; all logic on posedge
resetter  input  1  synchronous, active-high reset
play_req  input  NUM_SONGS  per-song request; a 1 in any cycle queues that song
stop  input  1  one-cycle abort of the current song
song_key_code  input  8*NUM_SONGS  key codes from the song modules; song i occupies bits [8i+7:8i]
song_enable  output  NUM_SONGS  drives each song module's active-low reset; 1 = run, 0 = held/rewound; at most one bit set
key_code  output  8  registered key code to the audio module
busy  output  1  high in START, PLAY and GAP
active_song  output  clog2(NUM_SONGS) (min 1)  index of the granted song; holds its last value in IDLE
done  output  1  one-cycle pulse when a song ends by silence

Behaviour:
- Reset (resetter=1 at posedge): state=IDLE, pending=0, song_enable=0, key_code=8'hf0, busy=0, active_song=0, done=0, all counters 0. Reset mid-song aborts immediately and does not pulse done.
- Pending update each cycle: pending_next = (pending & ~grant_mask) | play_req.
  - grant_mask is one-hot for the song granted this cycle, else 0.
  - A request for the song being granted in the same cycle therefore stays pending and replays after the current song.
- Grant selection: lowest set index of pending.
- IDLE:
  - key_code=f0, song_enable=0.
  - If pending!=0: grant the selected song, set active_song, and go to START next cycle.
- START:
  - song_enable=0, key_code=f0.
  - Counter runs 0..RESTART_CYCLES-1, then PLAY.
  - Exactly RESTART_CYCLES cycles are spent in START.
- PLAY:
  - song_enable[active_song]=1.
  - key_code <= selected song_key_code slice, registered, 1-cycle latency.
  - Silence counter (16 bit, saturating):
    - increments when the selected slice == 8'hf0;
    - clears to 0 on any other code.
  - When silence counter reaches SILENCE_LIMIT: go to GAP, pulse done for 1 cycle, and drop song_enable.
- GAP:
  - song_enable=0, key_code=f0.
  - Counter runs for max(GAP_CYCLES,1) cycles, then IDLE.
  - Requests keep queuing during GAP.
- stop:
  - In START or PLAY: go to GAP next cycle, with no done pulse.
  - The aborted song is not re-queued.
  - In IDLE or GAP: ignored.
- Preempt (PREEMPT=1, state PLAY or START):
  - Triggered if pending has a bit with index < active_song.
  - Grant that song and re-enter START, restarting its counter; no done pulse and no GAP.
  - The aborted song is not re-queued.
- Priority of simultaneous events, highest first: resetter, stop, preempt, silence-end.
- The key_code mux forces 8'hf0 outside PLAY, so no stale note leaks during START or GAP.
- Width rules: counters are 16-bit unsigned; parameters above 65535 are illegal.

Test Plan:
Bench config: NUM_SONGS=4, RESTART_CYCLES=4, SILENCE_LIMIT=16, GAP_CYCLES=8, PREEMPT=1; song models are driven by the bench.
- Single request:
  - Stimulus: play_req=4'b0100 for 1 cycle; song 2 emits 2b,34 then f0 forever.
  - Required: START for exactly 4 cycles with song_enable=0, then song_enable=4'b0100 and key_code follows song 2 one cycle late.
  - Required: done pulses 16 cycles after the first f0, then 8 GAP cycles, then IDLE with busy=0.
- Priority queue:
  - Stimulus: play_req=4'b1010 in the same cycle.
  - Required: song 1 plays first, song 3 plays after GAP; done pulses twice.
- Preemption:
  - Stimulus: song 2 in PLAY; play_req=4'b0001.
  - Required: next state START with active_song=0, no done pulse, and song 2 not replayed afterwards.
- Stop and replay-on-grant:
  - Stimulus A: stop pulse mid-PLAY.
  - Required A: GAP, no done, key_code=f0.
  - Stimulus B: play_req[1] asserted in the grant cycle of song 1.
  - Required B: song 1 plays twice.
- Silence reset:
  - Stimulus: song emits f0 for 15 cycles, then 42.
  - Required: silence counter clears and no done occurs.
- Synchronous reset:
  - Stimulus: assert resetter mid-PLAY.
  - Required: on the next posedge all outputs return to reset values (key_code=f0) and pending=0.
